// File: rtl/sine_ctrl_pkg.sv
// rtl/sine_ctrl_pkg.sv - shared types, defaults and LUT generator for the sine burst controller
package sine_ctrl_pkg;

    localparam int         DEF_PHASE_W = 16;
    localparam int         DEF_OUT_W   = 8;
    localparam int         LUT_IDX_W   = 10;
    localparam int         LUT_DEPTH   = 1 << LUT_IDX_W;
    localparam logic [7:0] MIDSCALE    = 8'h80;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    // round(127*sin(2*pi*k/1024)) via a Q30 Taylor series folded into the first quadrant
    function automatic logic signed [7:0] lut_entry(input int k);
        longint quad, q, x, x2, term, sum, v;
        quad = (longint'(k) >>> 8) & 64'sd3;
        q    = longint'(k) & 64'sd255;
        if (quad == 64'sd1 || quad == 64'sd3) q = 64'sd256 - q;
        x    = (q * 64'sd1686629713) >>> 8;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (longint n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 30) / (64'sd2 * n * (64'sd2 * n + 64'sd1));
            sum  = sum + term;
        end
        v = (64'sd127 * sum + (64'sd1 <<< 29)) >>> 30;
        if (quad >= 64'sd2) v = -v;
        return v[7:0];
    endfunction

endpackage

// File: rtl/sine_lut.sv
// rtl/sine_lut.sv - registered 1024-entry signed sine ROM, one-cycle latency
module sine_lut
    import sine_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic [LUT_IDX_W-1:0] idx_i,
    output logic signed [7:0]    val_o
);

    logic signed [7:0] rom [LUT_DEPTH];
    logic signed [7:0] val_q;

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
        localparam logic signed [7:0] ENTRY = lut_entry(k);
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk) begin
        val_q <= rom[idx_i];
    end

    assign val_o = val_q;

endmodule

// File: rtl/sine_burst_ctrl.sv
// rtl/sine_burst_ctrl.sv - command-driven sine burst generator with phase accumulator and amplitude scaling
module sine_burst_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PHASE_W-1:0] cmd_ftw,
    input  logic [7:0]         cmd_cycles,
    input  logic [7:0]         cmd_amp,
    input  logic               abort,
    output logic               busy,
    output logic [OUT_W-1:0]   sine_out,
    output logic               sine_valid,
    output logic               done,
    output logic               aborted
);

    state_e             state_q;
    logic [PHASE_W-1:0] acc_q, ftw_q;
    logic [7:0]         cycles_q, amp_q, per_cnt_q;
    logic               drain_q;
    logic               lut_vld_q, out_vld_q;
    logic [OUT_W-1:0]   sine_q;
    logic               done_q, aborted_q;

    logic [PHASE_W:0]       acc_sum_d;
    logic [LUT_IDX_W-1:0]   lut_idx;
    logic signed [7:0]      lut_val;
    logic signed [8:0]      scaled_d;
    logic signed [8:0]      biased_d;
    logic [OUT_W-1:0]       sine_d;

    sine_lut u_lut (
        .clk   (clk),
        .idx_i (lut_idx),
        .val_o (lut_val)
    );

    // Top bit of the sum is the period carry
    always_comb begin
        acc_sum_d = {1'b0, acc_q} + {1'b0, ftw_q};
        lut_idx   = acc_q[PHASE_W-1 -: LUT_IDX_W];
        scaled_d  = 9'((17'(lut_val) * 17'($signed({1'b0, amp_q}))) >>> 8);
        biased_d  = scaled_d + 9'sd128;
        sine_d    = OUT_W'(biased_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            ftw_q     <= '0;
            cycles_q  <= '0;
            amp_q     <= '0;
            per_cnt_q <= '0;
            drain_q   <= 1'b0;
            lut_vld_q <= 1'b0;
            out_vld_q <= 1'b0;
            sine_q    <= OUT_W'(MIDSCALE);
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            lut_vld_q <= (state_q == ST_RUN) && !abort;
            out_vld_q <= lut_vld_q && !abort;
            sine_q    <= (lut_vld_q && !abort) ? sine_d : OUT_W'(MIDSCALE);

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_cycles == 8'd0 || cmd_ftw == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            ftw_q     <= cmd_ftw;
                            cycles_q  <= cmd_cycles;
                            amp_q     <= cmd_amp;
                            acc_q     <= '0;
                            per_cnt_q <= '0;
                            state_q   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        acc_q <= acc_sum_d[PHASE_W-1:0];
                        if (acc_sum_d[PHASE_W]) begin
                            per_cnt_q <= per_cnt_q + 8'd1;
                            if (per_cnt_q + 8'd1 == cycles_q) begin
                                state_q <= ST_DRAIN;
                                drain_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (drain_q) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign busy       = (state_q != ST_IDLE);
    assign sine_out   = sine_q;
    assign sine_valid = out_vld_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

endmodule

// File: tb/tb_sine_burst_ctrl.sv
// tb/tb_sine_burst_ctrl.sv - self-checking bench for sine_burst_ctrl
module tb_sine_burst_ctrl;

    localparam real PI   = 3.14159265358979323846;
    localparam int  NONE = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_ftw;
    logic [7:0]  cmd_cycles;
    logic [7:0]  cmd_amp;
    logic        abort;
    logic        busy;
    logic [7:0]  sine_out;
    logic        sine_valid;
    logic        done;
    logic        aborted;

    int cmp_cnt = 0;
    int err_cnt = 0;

    sine_burst_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ftw    (cmd_ftw),
        .cmd_cycles (cmd_cycles),
        .cmd_amp    (cmd_amp),
        .abort      (abort),
        .busy       (busy),
        .sine_out   (sine_out),
        .sine_valid (sine_valid),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int ftw;
        int cyc;
        int amp;
        int abort_at;
        int exp_n;
        int exp_pk;
        int exp_tr;
        bit exp_ab;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Samples a burst produces: RUN lasts until the carry that completes period cyc
    function automatic int n_expected(input int ftw, input int cyc);
        return (cyc * 65536 + ftw - 1) / ftw;
    endfunction

    function automatic int model_sample(input int ftw, input int amp, input int i);
        longint ph;
        int     k, l;
        real    lv;
        ph = (longint'(i) * longint'(ftw)) % 64'sd65536;
        k  = int'(ph / 64'sd64);
        lv = 127.0 * $sin(2.0 * PI * k / 1024.0);
        l  = (lv >= 0.0) ? $rtoi(lv + 0.5) : -$rtoi(0.5 - lv);
        return $rtoi($floor(real'(l * amp) / 256.0)) + 128;
    endfunction

    task automatic burst(input int ftw, input int cyc, input int amp, input int abort_at,
                         input bit keep, input int nftw, input int ncyc, input int namp,
                         output int n_obs, output int pk, output int tr, output bit ab_obs);
        int n, t_done, w;
        bit zero, ab, ev;
        zero   = (cyc == 0) || (ftw == 0);
        n      = zero ? 0 : n_expected(ftw, cyc);
        ab     = !zero && (abort_at <= n + 2);
        t_done = zero ? 1 : (ab ? abort_at + 1 : n + 3);
        n_obs  = 0;
        pk     = -1;
        tr     = 256;
        ab_obs = 1'b0;
        w = 0;
        while (!cmd_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", int'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_ftw    = 16'(ftw);
        cmd_cycles = 8'(cyc);
        cmd_amp    = 8'(amp);
        @(negedge clk);
        for (int t = 1; t <= t_done; t++) begin
            ev = !zero && (t >= 3) && (t <= n + 2) && (t <= abort_at);
            check($sformatf("valid f=%0h t=%0d", ftw, t), int'(sine_valid), int'(ev));
            check($sformatf("sample f=%0h a=%0d t=%0d", ftw, amp, t), int'(sine_out),
                  ev ? model_sample(ftw, amp, t - 3) : 128);
            check($sformatf("done t=%0d", t), int'(done), int'(t == t_done));
            check($sformatf("aborted t=%0d", t), int'(aborted), int'(t == t_done && ab));
            check($sformatf("busy t=%0d", t), int'(busy), int'(t < t_done));
            check($sformatf("cmd_ready t=%0d", t), int'(cmd_ready), int'(t == t_done));
            if (sine_valid) begin
                n_obs++;
                if (int'(sine_out) > pk) pk = int'(sine_out);
                if (int'(sine_out) < tr) tr = int'(sine_out);
            end
            if (done) ab_obs = aborted;
            if (t == 1) begin
                if (keep) begin
                    cmd_ftw    = 16'(nftw);
                    cmd_cycles = 8'(ncyc);
                    cmd_amp    = 8'(namp);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            abort = (t == abort_at);
            if (t < t_done) @(negedge clk);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   n_obs, pk, tr;
        bit   ab_obs;
        int   rf, rc, ra, rab, rn;

        vecs[0] = '{ftw: 'h4000, cyc: 1, amp: 255, abort_at: NONE, exp_n: 4,  exp_pk: 254, exp_tr: 1,   exp_ab: 0};
        vecs[1] = '{ftw: 'h1000, cyc: 3, amp: 128, abort_at: NONE, exp_n: 48, exp_pk: 191, exp_tr: 64,  exp_ab: 0};
        vecs[2] = '{ftw: 'h0100, cyc: 2, amp: 255, abort_at: 20,   exp_n: 18, exp_pk: 178, exp_tr: 128, exp_ab: 1};
        vecs[3] = '{ftw: 'h4000, cyc: 0, amp: 255, abort_at: NONE, exp_n: 0,  exp_pk: -1,  exp_tr: 256, exp_ab: 0};
        vecs[4] = '{ftw: 'h0000, cyc: 2, amp: 255, abort_at: NONE, exp_n: 0,  exp_pk: -1,  exp_tr: 256, exp_ab: 0};
        vecs[5] = '{ftw: 'h4000, cyc: 2, amp: 0,   abort_at: NONE, exp_n: 8,  exp_pk: 128, exp_tr: 128, exp_ab: 0};

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ftw    = '0;
        cmd_cycles = '0;
        cmd_amp    = '0;
        abort      = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ready", int'(cmd_ready), 0);
            check("rst_valid", int'(sine_valid), 0);
            check("rst_out", int'(sine_out), 128);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", int'(cmd_ready), 1);
            check("idle_valid", int'(sine_valid), 0);
            check("idle_out", int'(sine_out), 128);
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
            check("idle_aborted", int'(aborted), 0);
            abort = (i >= 5);
        end
        @(negedge clk);
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_done", int'(done), 0);
        abort = 1'b0;

        for (int v = 0; v < 6; v++) begin
            burst(vecs[v].ftw, vecs[v].cyc, vecs[v].amp, vecs[v].abort_at, 1'b0, 0, 0, 0,
                  n_obs, pk, tr, ab_obs);
            check($sformatf("vec%0d count", v), n_obs, vecs[v].exp_n);
            check($sformatf("vec%0d peak", v), pk, vecs[v].exp_pk);
            check($sformatf("vec%0d trough", v), tr, vecs[v].exp_tr);
            check($sformatf("vec%0d aborted", v), int'(ab_obs), int'(vecs[v].exp_ab));
        end

        // Second command held during a burst must wait for IDLE
        burst('h4000, 1, 255, NONE, 1'b1, 'h2000, 2, 200, n_obs, pk, tr, ab_obs);
        check("hold_first_count", n_obs, 4);
        burst('h2000, 2, 200, NONE, 1'b0, 0, 0, 0, n_obs, pk, tr, ab_obs);
        check("hold_second_count", n_obs, 16);

        // abort together with cmd_valid in IDLE is a normal accept
        abort = 1'b1;
        burst('h4000, 1, 255, NONE, 1'b0, 0, 0, 0, n_obs, pk, tr, ab_obs);
        check("abort_idle_count", n_obs, 4);
        check("abort_idle_aborted", int'(ab_obs), 0);

        // Reset in the middle of a burst
        cmd_valid  = 1'b1;
        cmd_ftw    = 16'h1000;
        cmd_cycles = 8'd2;
        cmd_amp    = 8'd200;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("midrst_busy_before", int'(busy), 1);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_ready_in_rst", int'(cmd_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_valid", int'(sine_valid), 0);
        check("midrst_out", int'(sine_out), 128);
        check("midrst_done", int'(done), 0);
        check("midrst_aborted", int'(aborted), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(cmd_ready), 1);
        burst('h4000, 1, 255, NONE, 1'b0, 0, 0, 0, n_obs, pk, tr, ab_obs);
        check("midrst_next_count", n_obs, 4);

        for (int r = 0; r < 20; r++) begin
            rf  = int'($urandom_range(16'h0800, 16'hFFFF));
            rc  = int'($urandom_range(1, 6));
            ra  = int'($urandom_range(0, 255));
            rn  = n_expected(rf, rc);
            rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rn + 2)) : NONE;
            burst(rf, rc, ra, rab, 1'b0, 0, 0, 0, n_obs, pk, tr, ab_obs);
            check($sformatf("rand%0d count", r), n_obs,
                  (rab == NONE) ? rn : ((rab < 3) ? 0 : ((rab - 2 < rn) ? rab - 2 : rn)));
            check($sformatf("rand%0d aborted", r), int'(ab_obs), int'(rab != NONE));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
